// File: rtl/adc_scan_scheduler.sv
// Round-robin ADC channel scanner: select mux channel, settle, pulse SOC, await EOC with timeout, emit tagged sample.
// Latency: scan_enable in IDLE cycle n -> SOC in cycle n+2+SETTLE_CYCLES; EOC in cycle m -> tx_valid from m+1.
// Backpressure: SEND holds tx_valid/tx_data/tx_channel until tx_ready; no new conversion starts meanwhile.
module adc_scan_scheduler #(
   parameter int NUM_CH        = 4,
   parameter int SETTLE_CYCLES = 3,
   parameter int TIMEOUT       = 200
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_scan_enable,
   input  logic [NUM_CH-1:0] i_ch_mask,
   input  logic              i_eoc,
   input  logic [7:0]        i_data_in,
   input  logic              i_tx_ready,
   input  logic              i_err_clear,
   output logic              o_soc,
   output logic              o_mux_en,
   output logic [3:0]        o_canale,
   output logic              o_tx_valid,
   output logic [7:0]        o_tx_data,
   output logic [3:0]        o_tx_channel,
   output logic              o_busy,
   output logic              o_err_flag,
   output logic [3:0]        o_err_ch
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_SELECT, ST_SETTLE, ST_START, ST_WAIT_EOC, ST_SEND
   } state_t;

   state_t      r_state, w_state;
   logic [7:0]  r_cnt, w_cnt;
   logic [3:0]  r_last_ch, w_last_ch;
   logic        r_soc, w_soc;
   logic        r_mux_en, w_mux_en;
   logic [3:0]  r_canale, w_canale;
   logic        r_tx_valid, w_tx_valid;
   logic [7:0]  r_tx_data, w_tx_data;
   logic [3:0]  r_tx_channel, w_tx_channel;
   logic        r_busy, w_busy;
   logic        r_err_flag, w_err_flag;
   logic [3:0]  r_err_ch, w_err_ch;
   logic        w_err_set;

   logic [15:0] w_mask16;
   logic [4:0]  w_sum;
   logic [3:0]  w_pick;

   // Next enabled channel after last_ch; scanning farthest-first lets the nearest match win, last_ch itself is tried last.
   always_comb begin
      w_mask16 = 16'(i_ch_mask);
      w_sum    = '0;
      w_pick   = r_last_ch;
      for (int i = NUM_CH; i >= 1; i--) begin
         w_sum = 5'(r_last_ch) + 5'(i);
         if (w_sum >= 5'(NUM_CH)) begin
            w_sum = w_sum - 5'(NUM_CH);
         end
         if (w_mask16[w_sum[3:0]]) begin
            w_pick = w_sum[3:0];
         end
      end
   end

   // Next-state and next-output logic; every output register is loaded from these values.
   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_last_ch    = r_last_ch;
      w_soc        = 1'b0;
      w_mux_en     = r_mux_en;
      w_canale     = r_canale;
      w_tx_valid   = r_tx_valid;
      w_tx_data    = r_tx_data;
      w_tx_channel = r_tx_channel;
      w_err_ch     = r_err_ch;
      w_err_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_scan_enable && (|i_ch_mask)) begin
               w_canale  = w_pick;
               w_last_ch = w_pick;
               w_state   = ST_SELECT;
            end
         end
         ST_SELECT: begin
            w_mux_en = 1'b1;
            w_cnt    = 8'(SETTLE_CYCLES);
            w_state  = ST_SETTLE;
         end
         ST_SETTLE: begin
            // EOC is deliberately ignored while the mux settles.
            w_cnt = r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
               w_soc   = 1'b1;
               w_state = ST_START;
            end
         end
         ST_START: begin
            w_cnt   = '0;
            w_state = ST_WAIT_EOC;
         end
         ST_WAIT_EOC: begin
            w_cnt = r_cnt + 8'd1;
            // EOC takes priority over a coincident timeout.
            if (i_eoc) begin
               w_tx_data    = i_data_in;
               w_tx_channel = r_canale;
               w_tx_valid   = 1'b1;
               w_mux_en     = 1'b0;
               w_state      = ST_SEND;
            end else if (r_cnt == 8'(TIMEOUT)) begin
               w_err_set = 1'b1;
               w_err_ch  = r_canale;
               w_mux_en  = 1'b0;
               w_state   = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (i_tx_ready) begin
               w_tx_valid = 1'b0;
               w_state    = ST_IDLE;
            end
         end
         default: begin
            w_state = ST_IDLE;
         end
      endcase
      w_busy     = (w_state != ST_IDLE);
      // A new timeout beats a simultaneous clear.
      w_err_flag = w_err_set ? 1'b1 : (i_err_clear ? 1'b0 : r_err_flag);
   end

   // State and output registers; reset clears all outputs and rewinds the pointer so the lowest channel goes first.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_last_ch    <= 4'(NUM_CH - 1);
         r_soc        <= 1'b0;
         r_mux_en     <= 1'b0;
         r_canale     <= '0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= '0;
         r_tx_channel <= '0;
         r_busy       <= 1'b0;
         r_err_flag   <= 1'b0;
         r_err_ch     <= '0;
      end else begin
         r_state      <= w_state;
         r_cnt        <= w_cnt;
         r_last_ch    <= w_last_ch;
         r_soc        <= w_soc;
         r_mux_en     <= w_mux_en;
         r_canale     <= w_canale;
         r_tx_valid   <= w_tx_valid;
         r_tx_data    <= w_tx_data;
         r_tx_channel <= w_tx_channel;
         r_busy       <= w_busy;
         r_err_flag   <= w_err_flag;
         r_err_ch     <= w_err_ch;
      end
   end

   assign o_soc        = r_soc;
   assign o_mux_en     = r_mux_en;
   assign o_canale     = r_canale;
   assign o_tx_valid   = r_tx_valid;
   assign o_tx_data    = r_tx_data;
   assign o_tx_channel = r_tx_channel;
   assign o_busy       = r_busy;
   assign o_err_flag   = r_err_flag;
   assign o_err_ch     = r_err_ch;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler (NUM_CH=4, SETTLE_CYCLES=3, TIMEOUT=5).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Every expected value below is a hand-derived constant from the cycle timeline.
module tb_adc_scan_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_en;
   logic [3:0] mask;
   logic       eoc;
   logic [7:0] din;
   logic       tx_rdy;
   logic       err_clr;
   logic       soc, mux_en, tx_vld, busy, err_flag;
   logic [3:0] canale, tx_ch, err_ch;
   logic [7:0] tx_dat;

   int checks = 0;
   int errors = 0;

   adc_scan_scheduler #(
      .NUM_CH(4), .SETTLE_CYCLES(3), .TIMEOUT(5)
   ) dut (
      .i_clock(clk), .i_reset(rst), .i_scan_enable(scan_en), .i_ch_mask(mask),
      .i_eoc(eoc), .i_data_in(din), .i_tx_ready(tx_rdy), .i_err_clear(err_clr),
      .o_soc(soc), .o_mux_en(mux_en), .o_canale(canale), .o_tx_valid(tx_vld),
      .o_tx_data(tx_dat), .o_tx_channel(tx_ch), .o_busy(busy),
      .o_err_flag(err_flag), .o_err_ch(err_ch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for the next SOC pulse.
   task automatic wait_soc();
      int n = 0;
      while (soc !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("soc_seen", {31'd0, soc}, 32'd1);
   endtask

   logic [3:0] rr_exp [5] = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1};

   initial begin
      rst = 1'b1; scan_en = 1'b0; mask = 4'b0000; eoc = 1'b0;
      din = 8'h00; tx_rdy = 1'b0; err_clr = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_soc", {31'd0, soc}, 0);
      chk("rst_mux_en", {31'd0, mux_en}, 0);
      chk("rst_canale", {28'd0, canale}, 0);
      chk("rst_tx_valid", {31'd0, tx_vld}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_err_flag", {31'd0, err_flag}, 0);
      rst = 1'b0;
      tick();

      // Single channel 2: scan_enable in cycle 0, SOC in cycle 5, EOC in cycle 7
      mask = 4'b0100; scan_en = 1'b1; tx_rdy = 1'b1;
      tick();                                   // cycle 1: SELECT
      scan_en = 1'b0;
      chk("t1_canale", {28'd0, canale}, 2);
      chk("t1_busy_c1", {31'd0, busy}, 1);
      chk("t1_mux_c1", {31'd0, mux_en}, 0);
      chk("t1_soc_c1", {31'd0, soc}, 0);
      tick();                                   // cycle 2
      chk("t1_mux_c2", {31'd0, mux_en}, 1);
      chk("t1_soc_c2", {31'd0, soc}, 0);
      tick();
      chk("t1_soc_c3", {31'd0, soc}, 0);
      tick();
      chk("t1_soc_c4", {31'd0, soc}, 0);
      tick();                                   // cycle 5: START
      chk("t1_soc_c5", {31'd0, soc}, 1);
      tick();                                   // cycle 6
      chk("t1_soc_c6", {31'd0, soc}, 0);
      chk("t1_txv_c6", {31'd0, tx_vld}, 0);
      tick();                                   // cycle 7: EOC
      eoc = 1'b1; din = 8'hA5;
      tick();                                   // cycle 8: SEND, handshake
      eoc = 1'b0;
      chk("t1_txv_c8", {31'd0, tx_vld}, 1);
      chk("t1_txdat", {24'd0, tx_dat}, 32'hA5);
      chk("t1_txch", {28'd0, tx_ch}, 2);
      chk("t1_mux_c8", {31'd0, mux_en}, 0);
      tick();                                   // cycle 9: IDLE
      chk("t1_txv_c9", {31'd0, tx_vld}, 0);
      chk("t1_busy_c9", {31'd0, busy}, 0);
      chk("t1_txdat_hold", {24'd0, tx_dat}, 32'hA5);
      chk("t1_canale_hold", {28'd0, canale}, 2);

      // Round robin over mask 1011 from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mask = 4'b1011; scan_en = 1'b1; tx_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_soc();
         chk("rr_canale", {28'd0, canale}, {28'd0, rr_exp[i]});
         tick();
         eoc = 1'b1; din = 8'h10 + 8'(i);
         tick();
         eoc = 1'b0;
         if (i == 4) scan_en = 1'b0;
         chk("rr_txv", {31'd0, tx_vld}, 1);
         chk("rr_txch", {28'd0, tx_ch}, {28'd0, rr_exp[i]});
         chk("rr_txdat", {24'd0, tx_dat}, 32'h10 + i);
      end
      tick();
      chk("rr_idle", {31'd0, busy}, 0);

      // Backpressure: tx_ready low for 10 cycles after tx_valid rises (next channel is 3)
      tx_rdy = 1'b0; scan_en = 1'b1;
      wait_soc();
      chk("bp_canale", {28'd0, canale}, 3);
      tick();
      eoc = 1'b1; din = 8'h3C;
      tick();
      eoc = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("bp_txv", {31'd0, tx_vld}, 1);
         chk("bp_txdat", {24'd0, tx_dat}, 32'h3C);
         chk("bp_txch", {28'd0, tx_ch}, 3);
         chk("bp_nosoc", {31'd0, soc}, 0);
         tick();
      end
      chk("bp_txv_last", {31'd0, tx_vld}, 1);
      tx_rdy = 1'b1; scan_en = 1'b0;
      tick();
      chk("bp_idle_busy", {31'd0, busy}, 0);
      chk("bp_idle_txv", {31'd0, tx_vld}, 0);
      tick();
      chk("bp_stay_idle", {31'd0, busy}, 0);

      // Timeout on channel 1 (mask 1010), scan continues with channel 3
      mask = 4'b1010; scan_en = 1'b1;
      tick();                                   // n+1
      chk("to_canale", {28'd0, canale}, 1);
      tick(); tick(); tick(); tick();           // n+5
      chk("to_soc", {31'd0, soc}, 1);
      for (int k = 0; k < 6; k++) begin         // WAIT_EOC cycles n+6..n+11
         tick();
         chk("to_txv_wait", {31'd0, tx_vld}, 0);
         chk("to_err_wait", {31'd0, err_flag}, 0);
         chk("to_busy_wait", {31'd0, busy}, 1);
      end
      tick();                                   // n+12: aborted
      chk("to_err_flag", {31'd0, err_flag}, 1);
      chk("to_err_ch", {28'd0, err_ch}, 1);
      chk("to_busy", {31'd0, busy}, 0);
      chk("to_mux_en", {31'd0, mux_en}, 0);
      chk("to_txv", {31'd0, tx_vld}, 0);
      tick();                                   // n+13: next channel
      scan_en = 1'b0;
      chk("to_next_canale", {28'd0, canale}, 3);
      chk("to_next_busy", {31'd0, busy}, 1);
      wait_soc();
      tick();
      eoc = 1'b1; din = 8'h5A;
      tick();
      eoc = 1'b0;
      chk("to_next_txch", {28'd0, tx_ch}, 3);
      chk("to_sticky_flag", {31'd0, err_flag}, 1);
      chk("to_sticky_ch", {28'd0, err_ch}, 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("to_cleared", {31'd0, err_flag}, 0);

      // EOC during SETTLE ignored; EOC coincident with timeout gives a sample, no error
      mask = 4'b0001; scan_en = 1'b1;
      tick();                                   // n+1
      scan_en = 1'b0;
      chk("bd_canale", {28'd0, canale}, 0);
      tick();                                   // n+2..n+4: EOC high during SETTLE
      eoc = 1'b1; din = 8'hEE;
      tick(); tick(); tick();                   // n+5
      eoc = 1'b0;
      chk("bd_soc", {31'd0, soc}, 1);
      chk("bd_txv_start", {31'd0, tx_vld}, 0);
      for (int k = 0; k < 5; k++) begin         // n+6..n+10
         tick();
         chk("bd_txv_wait", {31'd0, tx_vld}, 0);
      end
      tick();                                   // n+11: counter at TIMEOUT
      eoc = 1'b1; din = 8'h77;
      tick();                                   // n+12
      eoc = 1'b0;
      chk("bd_tie_txv", {31'd0, tx_vld}, 1);
      chk("bd_tie_txdat", {24'd0, tx_dat}, 32'h77);
      chk("bd_tie_err", {31'd0, err_flag}, 0);
      tick();
      chk("bd_tie_idle", {31'd0, busy}, 0);

      // Asynchronous reset in WAIT_EOC, then lowest enabled channel first
      mask = 4'b0110; scan_en = 1'b1;
      tick();
      scan_en = 1'b0;
      chk("ar_canale", {28'd0, canale}, 1);
      tick(); tick(); tick(); tick(); tick();   // n+6: WAIT_EOC
      chk("ar_in_wait", {31'd0, mux_en}, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_soc", {31'd0, soc}, 0);
      chk("ar_mux_en", {31'd0, mux_en}, 0);
      chk("ar_canale0", {28'd0, canale}, 0);
      chk("ar_txv", {31'd0, tx_vld}, 0);
      chk("ar_txdat", {24'd0, tx_dat}, 0);
      chk("ar_txch", {28'd0, tx_ch}, 0);
      chk("ar_busy", {31'd0, busy}, 0);
      chk("ar_err_flag", {31'd0, err_flag}, 0);
      chk("ar_err_ch", {28'd0, err_ch}, 0);
      tick();
      rst = 1'b0;
      scan_en = 1'b1;
      tick();
      scan_en = 1'b0;
      chk("ar_first_canale", {28'd0, canale}, 1);
      chk("ar_first_busy", {31'd0, busy}, 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
